// File: rtl/r5p_csr_master_pkg.sv
// -----------------------------------------------------------------------------
// r5p_csr_master_pkg
// Shared types for the CSR access initiator:
//   csr_mop_t  - request operation (read / write / set bits / clear bits)
//   csr_merr_t - response error code (ok / timeout / read-only / verify)
// Zicsr funct3 encodings and small helpers used when driving the CSR port.
// -----------------------------------------------------------------------------
package r5p_csr_master_pkg;

    typedef enum logic [1:0] {
        CSR_MOP_READ  = 2'b00,
        CSR_MOP_WRITE = 2'b01,
        CSR_MOP_SET   = 2'b10,
        CSR_MOP_CLEAR = 2'b11
    } csr_mop_t;

    typedef enum logic [1:0] {
        CSR_MERR_OK  = 2'b00,
        CSR_MERR_TMO = 2'b01,
        CSR_MERR_RO  = 2'b10,
        CSR_MERR_VFY = 2'b11
    } csr_merr_t;

    localparam logic [2:0] CSR_FN3_NONE = 3'b000;
    localparam logic [2:0] CSR_FN3_RW   = 3'b001;
    localparam logic [2:0] CSR_FN3_RS   = 3'b010;
    localparam logic [2:0] CSR_FN3_RC   = 3'b011;

    // A plain read is issued as CSRRS with the write strobe held low,
    // exactly as the decoder does for "csrrs rd, csr, x0".
    function automatic logic [2:0] csr_fn3_of(input csr_mop_t op);
        logic [2:0] fn3;
        case (op)
            CSR_MOP_READ:  fn3 = CSR_FN3_RS;
            CSR_MOP_WRITE: fn3 = CSR_FN3_RW;
            CSR_MOP_SET:   fn3 = CSR_FN3_RS;
            CSR_MOP_CLEAR: fn3 = CSR_FN3_RC;
            default:       fn3 = CSR_FN3_NONE;
        endcase
        return fn3;
    endfunction

    // CSR address space encodes read-only registers as adr[11:10] == 2'b11.
    function automatic logic csr_is_ro(input logic [11:0] adr);
        return (adr[11:10] == 2'b11);
    endfunction

endpackage

// File: rtl/r5p_csr_master.sv
// -----------------------------------------------------------------------------
// r5p_csr_master
// CSR access initiator for debug / bring-up. Takes one read/write/set/clear
// request at a time, wins the CSR port from the pipeline (own_req/own_gnt),
// performs a single CSR access and returns the pre-access value plus an
// error code. Gives up with a timeout error if the pipeline does not grant
// within 2**TMO_W-1 cycles.
//
// Optional build macro: R5P_CSR_MASTER_VERIFY_EN
//   When defined, every write-class access that is not blocked as read-only
//   is followed by a one-cycle read-back; a value other than the intended
//   result (WARL masking) yields the verify-mismatch error code.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_vld/req_rdy/req_op/req_adr/req_wdt   request channel
//   rsp_vld/rsp_rdy/rsp_rdt/rsp_err          response channel
//   own_req/own_gnt                CSR port ownership handshake with pipeline
//   csr_ren/csr_wen/csr_adr/csr_fn3/csr_wdt  CSR file port (driven)
//   csr_rdt                        CSR read data (combinational from csr_adr)
// All outputs are registered.
// -----------------------------------------------------------------------------
module r5p_csr_master
    import r5p_csr_master_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TMO_W = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [1:0]       req_op,
    input  logic [11:0]      req_adr,
    input  logic [XLEN-1:0]  req_wdt,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [XLEN-1:0]  rsp_rdt,
    output logic [1:0]       rsp_err,
    output logic             own_req,
    input  logic             own_gnt,
    output logic             csr_ren,
    output logic             csr_wen,
    output logic [11:0]      csr_adr,
    output logic [2:0]       csr_fn3,
    output logic [XLEN-1:0]  csr_wdt,
    input  logic [XLEN-1:0]  csr_rdt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_ACC  = 3'd2,
`ifdef R5P_CSR_MASTER_VERIFY_EN
        ST_VFY  = 3'd3,
`endif
        ST_RSP  = 3'd4
    } state_t;

    // Counter value at which the next ungranted ARB cycle gives up: the
    // counter then reaches all-ones after 2**TMO_W-1 cycles in ARB.
    localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t            state_r,   state_nxt_s;
    csr_mop_t          op_r,      op_nxt_s;
    logic [11:0]       adr_r,     adr_nxt_s;
    logic [XLEN-1:0]   wdt_r,     wdt_nxt_s;
    logic [TMO_W-1:0]  cnt_r,     cnt_nxt_s;

    logic              req_rdy_r, req_rdy_s;
    logic              rsp_vld_r, rsp_vld_s;
    logic [XLEN-1:0]   rsp_rdt_r, rsp_rdt_s;
    csr_merr_t         rsp_err_r, rsp_err_s;
    logic              own_req_r, own_req_s;
    logic              csr_ren_r, csr_ren_s;
    logic              csr_wen_r, csr_wen_s;
    logic [11:0]       csr_adr_r, csr_adr_s;
    logic [2:0]        csr_fn3_r, csr_fn3_s;
    logic [XLEN-1:0]   csr_wdt_r, csr_wdt_s;

    logic              wr_cls_s;
    logic              ro_s;
    logic              wen_ok_s;

    assign wr_cls_s = (op_r != CSR_MOP_READ);
    assign ro_s     = csr_is_ro(adr_r);
    assign wen_ok_s = wr_cls_s && !ro_s;

`ifdef R5P_CSR_MASTER_VERIFY_EN
    // Value the CSR should hold after a successful write-class access.
    function automatic logic [XLEN-1:0] vfy_expect(input csr_mop_t op,
                                                   input logic [XLEN-1:0] old,
                                                   input logic [XLEN-1:0] msk);
        logic [XLEN-1:0] val;
        case (op)
            CSR_MOP_WRITE: val = msk;
            CSR_MOP_SET:   val = old | msk;
            CSR_MOP_CLEAR: val = old & ~msk;
            default:       val = old;
        endcase
        return val;
    endfunction
`endif

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so that every port comes straight from a flop.
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        adr_nxt_s   = adr_r;
        wdt_nxt_s   = wdt_r;
        cnt_nxt_s   = cnt_r;
        req_rdy_s   = 1'b0;
        rsp_vld_s   = 1'b0;
        rsp_rdt_s   = rsp_rdt_r;
        rsp_err_s   = rsp_err_r;
        own_req_s   = 1'b0;
        csr_ren_s   = 1'b0;
        csr_wen_s   = 1'b0;
        csr_adr_s   = 12'h000;
        csr_fn3_s   = CSR_FN3_NONE;
        csr_wdt_s   = {XLEN{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (req_vld && req_rdy_r) begin
                    op_nxt_s    = csr_mop_t'(req_op);
                    adr_nxt_s   = req_adr;
                    wdt_nxt_s   = req_wdt;
                    cnt_nxt_s   = {TMO_W{1'b0}};
                    state_nxt_s = ST_ARB;
                    own_req_s   = 1'b1;
                end else begin
                    req_rdy_s   = 1'b1;
                end
            end

            ST_ARB: begin
                // Grant takes priority over a coincident terminal count.
                if (own_gnt) begin
                    state_nxt_s = ST_ACC;
                    own_req_s   = 1'b1;
                    csr_ren_s   = 1'b1;
                    csr_wen_s   = wen_ok_s;
                    csr_adr_s   = adr_r;
                    csr_fn3_s   = csr_fn3_of(op_r);
                    csr_wdt_s   = wdt_r;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    state_nxt_s = ST_RSP;
                    rsp_vld_s   = 1'b1;
                    rsp_rdt_s   = {XLEN{1'b0}};
                    rsp_err_s   = CSR_MERR_TMO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                    own_req_s   = 1'b1;
                end
            end

            ST_ACC: begin
                // Pre-access value; own_gnt is deliberately not looked at here.
                rsp_rdt_s = csr_rdt;
`ifdef R5P_CSR_MASTER_VERIFY_EN
                if (wen_ok_s) begin
                    state_nxt_s = ST_VFY;
                    own_req_s   = 1'b1;
                    csr_ren_s   = 1'b1;
                    csr_adr_s   = adr_r;
                    csr_fn3_s   = CSR_FN3_RS;
                    rsp_err_s   = CSR_MERR_OK;
                end else begin
                    state_nxt_s = ST_RSP;
                    rsp_vld_s   = 1'b1;
                    if (wr_cls_s && ro_s) begin
                        rsp_err_s = CSR_MERR_RO;
                    end else begin
                        rsp_err_s = CSR_MERR_OK;
                    end
                end
`else
                state_nxt_s = ST_RSP;
                rsp_vld_s   = 1'b1;
                if (wr_cls_s && ro_s) begin
                    rsp_err_s = CSR_MERR_RO;
                end else begin
                    rsp_err_s = CSR_MERR_OK;
                end
`endif
            end

`ifdef R5P_CSR_MASTER_VERIFY_EN
            ST_VFY: begin
                // rsp_rdt_r still holds the pre-access value used as "old".
                state_nxt_s = ST_RSP;
                rsp_vld_s   = 1'b1;
                if (csr_rdt != vfy_expect(op_r, rsp_rdt_r, wdt_r)) begin
                    rsp_err_s = CSR_MERR_VFY;
                end else begin
                    rsp_err_s = CSR_MERR_OK;
                end
            end
`endif

            ST_RSP: begin
                if (rsp_rdy) begin
                    state_nxt_s = ST_IDLE;
                    req_rdy_s   = 1'b1;
                end else begin
                    rsp_vld_s   = 1'b1;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                req_rdy_s   = 1'b1;
            end
        endcase
    end

    // State register plus latched request and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= CSR_MOP_READ;
            adr_r   <= 12'h000;
            wdt_r   <= {XLEN{1'b0}};
            cnt_r   <= {TMO_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            adr_r   <= adr_nxt_s;
            wdt_r   <= wdt_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_rdy_r <= 1'b1;
            rsp_vld_r <= 1'b0;
            rsp_rdt_r <= {XLEN{1'b0}};
            rsp_err_r <= CSR_MERR_OK;
            own_req_r <= 1'b0;
            csr_ren_r <= 1'b0;
            csr_wen_r <= 1'b0;
            csr_adr_r <= 12'h000;
            csr_fn3_r <= CSR_FN3_NONE;
            csr_wdt_r <= {XLEN{1'b0}};
        end else begin
            req_rdy_r <= req_rdy_s;
            rsp_vld_r <= rsp_vld_s;
            rsp_rdt_r <= rsp_rdt_s;
            rsp_err_r <= rsp_err_s;
            own_req_r <= own_req_s;
            csr_ren_r <= csr_ren_s;
            csr_wen_r <= csr_wen_s;
            csr_adr_r <= csr_adr_s;
            csr_fn3_r <= csr_fn3_s;
            csr_wdt_r <= csr_wdt_s;
        end
    end

    assign req_rdy = req_rdy_r;
    assign rsp_vld = rsp_vld_r;
    assign rsp_rdt = rsp_rdt_r;
    assign rsp_err = rsp_err_r;
    assign own_req = own_req_r;
    assign csr_ren = csr_ren_r;
    assign csr_wen = csr_wen_r;
    assign csr_adr = csr_adr_r;
    assign csr_fn3 = csr_fn3_r;
    assign csr_wdt = csr_wdt_r;

endmodule

// File: tb/tb_r5p_csr_master.sv
// -----------------------------------------------------------------------------
// tb_r5p_csr_master
// Directed bench for r5p_csr_master (TMO_W = 4). A small CSR file model
// answers the CSR port. The driver pushes the hand-computed response and the
// expected CSR port accesses into queues; an independent monitor pops and
// compares whenever the DUT strobes the CSR port or raises rsp_vld.
// -----------------------------------------------------------------------------
module tb_r5p_csr_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_op;
    logic [11:0] req_adr;
    logic [31:0] req_wdt;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdt;
    logic [1:0]  rsp_err;
    logic        own_req;
    logic        own_gnt;
    logic        csr_ren;
    logic        csr_wen;
    logic [11:0] csr_adr;
    logic [2:0]  csr_fn3;
    logic [31:0] csr_wdt;
    logic [31:0] csr_rdt;

    r5p_csr_master #(.XLEN(32), .TMO_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
        .req_adr(req_adr), .req_wdt(req_wdt),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdt(rsp_rdt), .rsp_err(rsp_err),
        .own_req(own_req), .own_gnt(own_gnt),
        .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_adr(csr_adr),
        .csr_fn3(csr_fn3), .csr_wdt(csr_wdt), .csr_rdt(csr_rdt)
    );

    always #5 clk = ~clk;

`ifdef R5P_CSR_MASTER_VERIFY_EN
    localparam int VL = 1;
`else
    localparam int VL = 0;
`endif

    // ---------------- CSR file model ----------------
    logic [31:0] r300, r340, rc00, r305;

    function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] msk,
                                        input logic [2:0] fn3, input logic [31:0] wdt);
        case (fn3)
            3'b001:  return wdt & msk;
            3'b010:  return (old | wdt) & msk;
            3'b011:  return (old & ~wdt) & msk;
            default: return old;
        endcase
    endfunction

    always_comb begin
        case (csr_adr)
            12'h300: csr_rdt = r300;
            12'h340: csr_rdt = r340;
            12'hC00: csr_rdt = rc00;
            12'h305: csr_rdt = r305;
            default: csr_rdt = 32'h0;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r300 <= 32'h0000_1800;
            r340 <= 32'h1234_5678;
            rc00 <= 32'h0000_0042;
            r305 <= 32'h0000_0000;
        end else if (csr_wen) begin
            case (csr_adr)
                12'h300: r300 <= upd(r300, 32'hFFFF_FFFF, csr_fn3, csr_wdt);
                12'h340: r340 <= upd(r340, 32'hFFFF_FFFF, csr_fn3, csr_wdt);
                12'h305: r305 <= upd(r305, 32'h0000_000F, csr_fn3, csr_wdt);
                default: ;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] rdt; logic [1:0] err; int lat; } rsp_t;
    typedef struct { logic wen; logic [2:0] fn3; logic [11:0] adr; logic [31:0] wdt; } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int hs_cyc      = 0;
    int done_cnt    = 0;
    int own_cnt     = 0;
    logic vld_d     = 1'b0;
    rsp_t cur;
    acc_t a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected / not seen", nm);
    endtask

    // Monitor: checks every CSR strobe and every response against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (own_req) own_cnt++;
            if (csr_wen && !csr_ren) flag("csr_wen_without_ren");
            if (csr_ren) begin
                if (acc_q.size() == 0) begin
                    flag("unexpected_csr_access");
                end else begin
                    a = acc_q.pop_front();
                    chk("csr_wen", 32'(csr_wen), 32'(a.wen));
                    chk("csr_fn3", 32'(csr_fn3), 32'(a.fn3));
                    chk("csr_adr", 32'(csr_adr), 32'(a.adr));
                    chk("csr_wdt", csr_wdt, a.wdt);
                end
            end
            if (rsp_vld && !vld_d) begin
                if (rsp_q.size() == 0) begin
                    flag("unexpected_rsp");
                end else begin
                    cur = rsp_q.pop_front();
                    chk("rsp_rdt", rsp_rdt, cur.rdt);
                    chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                    chk("rsp_latency", 32'(cyc - hs_cyc), 32'(cur.lat));
                end
            end else if (rsp_vld) begin
                chk("rsp_rdt_stable", rsp_rdt, cur.rdt);
                chk("rsp_err_stable", 32'(rsp_err), 32'(cur.err));
            end
            if (rsp_vld && rsp_rdy) done_cnt++;
            vld_d = rsp_vld;
        end else begin
            vld_d = 1'b0;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [31:0] rdt, input logic [1:0] err, input int lat);
        rsp_t r;
        r.rdt = rdt; r.err = err; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic push_acc(input logic wen, input logic [2:0] fn3,
                            input logic [11:0] adr, input logic [31:0] wdt);
        acc_t x;
        x.wen = wen; x.fn3 = fn3; x.adr = adr; x.wdt = wdt;
        acc_q.push_back(x);
    endtask

    task automatic send(input logic [1:0] op, input logic [11:0] adr, input logic [31:0] wdt);
        int n;
        n = 0;
        while (!req_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!req_rdy) flag("req_rdy_timeout");
        req_op  = op;
        req_adr = adr;
        req_wdt = wdt;
        req_vld = 1'b1;
        tick();
        hs_cyc  = cyc;
        req_vld = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt < target) flag("rsp_wait_timeout");
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 32'h1);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'h0);
        chk({tag, "_rsp_rdt"}, rsp_rdt, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_own_req"}, 32'(own_req), 32'h0);
        chk({tag, "_csr_ren"}, 32'(csr_ren), 32'h0);
        chk({tag, "_csr_wen"}, 32'(csr_wen), 32'h0);
        chk({tag, "_csr_adr"}, 32'(csr_adr), 32'h0);
        chk({tag, "_csr_fn3"}, 32'(csr_fn3), 32'h0);
        chk({tag, "_csr_wdt"}, csr_wdt, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nd;
        int own_base;
        int n;
        rst = 1'b1; req_vld = 1'b0; req_op = 2'b00; req_adr = 12'h000;
        req_wdt = 32'h0; rsp_rdy = 1'b1; own_gnt = 1'b1;
        nd = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // 1: read 0x300
        push_acc(1'b0, 3'b010, 12'h300, 32'h0);
        push_rsp(32'h0000_1800, 2'b00, 2);
        send(2'b00, 12'h300, 32'h0); nd++; wait_done(nd);

        // 2: write 0x340
        push_acc(1'b1, 3'b001, 12'h340, 32'hDEAD_BEEF);
        if (VL != 0) push_acc(1'b0, 3'b010, 12'h340, 32'h0);
        push_rsp(32'h1234_5678, 2'b00, 2 + VL);
        send(2'b01, 12'h340, 32'hDEAD_BEEF); nd++; wait_done(nd);

        // 3: clear bit 3 of 0x300, then set it, then read it back
        push_acc(1'b1, 3'b011, 12'h300, 32'h8);
        if (VL != 0) push_acc(1'b0, 3'b010, 12'h300, 32'h0);
        push_rsp(32'h0000_1800, 2'b00, 2 + VL);
        send(2'b11, 12'h300, 32'h8); nd++; wait_done(nd);

        push_acc(1'b1, 3'b010, 12'h300, 32'h8);
        if (VL != 0) push_acc(1'b0, 3'b010, 12'h300, 32'h0);
        push_rsp(32'h0000_1800, 2'b00, 2 + VL);
        send(2'b10, 12'h300, 32'h8); nd++; wait_done(nd);

        push_acc(1'b0, 3'b010, 12'h300, 32'h0);
        push_rsp(32'h0000_1808, 2'b00, 2);
        send(2'b00, 12'h300, 32'h0); nd++; wait_done(nd);

        // 4: write to read-only cycle counter
        push_acc(1'b0, 3'b001, 12'hC00, 32'h55);
        push_rsp(32'h0000_0042, 2'b10, 2);
        send(2'b01, 12'hC00, 32'h55); nd++; wait_done(nd);

        // late grant: two ungranted ARB cycles
        own_gnt = 1'b0;
        push_acc(1'b0, 3'b010, 12'h340, 32'h0);
        push_rsp(32'hDEAD_BEEF, 2'b00, 4);
        send(2'b00, 12'h340, 32'h0);
        tick(); tick();
        own_gnt = 1'b1;
        nd++; wait_done(nd);

        // 5: timeout with response back-pressure
        own_gnt = 1'b0;
        rsp_rdy = 1'b0;
        own_base = own_cnt;
        push_rsp(32'h0, 2'b01, 15);
        send(2'b00, 12'h300, 32'h0);
        n = 0;
        while (!rsp_vld && n < 40) begin
            tick();
            n++;
        end
        if (!rsp_vld) flag("timeout_rsp_missing");
        repeat (5) tick();
        chk("rsp_vld_held", 32'(rsp_vld), 32'h1);
        rsp_rdy = 1'b1;
        nd++; wait_done(nd);
        chk("own_req_cycles", 32'(own_cnt - own_base), 32'd15);
        own_gnt = 1'b1;

        // WARL-masked write: only the low nibble of 0x305 is writable
        push_acc(1'b1, 3'b001, 12'h305, 32'hFFFF_FFFF);
        if (VL != 0) push_acc(1'b0, 3'b010, 12'h305, 32'h0);
        push_rsp(32'h0, (VL != 0) ? 2'b11 : 2'b00, 2 + VL);
        send(2'b01, 12'h305, 32'hFFFF_FFFF); nd++; wait_done(nd);

        // 6: reset while arbitrating; no response may follow
        own_gnt = 1'b0;
        send(2'b01, 12'h340, 32'hAAAA_5555);
        tick(); tick();
        chk("arb_own_req", 32'(own_req), 32'h1);
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        tick();
        rst = 1'b0;
        own_gnt = 1'b1;
        repeat (20) tick();
        chk("no_rsp_after_rst", 32'(done_cnt), 32'(nd));
        chk("idle_after_rst", 32'(req_rdy), 32'h1);

        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
        chk("acc_queue_empty", 32'(acc_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/r5p_csr_master.md
Name: r5p_csr_master

Overview:
CSR access initiator driving the CSR file's read/write port, mirroring what the Zicsr decoder does during normal execution.
- Accepts read/write/set/clear requests from a debug or bring-up transport over a valid/ready handshake.
- Arbitrates with the pipeline for ownership of the CSR port and performs one CSR access per request.
- Returns the pre-access CSR value plus an error code on a valid/ready response channel.

Parameters:
XLEN, 32, CSR data width
TMO_W, 8, timeout counter width; arbitration gives up after 2**TMO_W-1 cycles without grant

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
req_vld  input  1  request valid
req_rdy  output  1  request ready
req_op  input  2  00 read, 01 write, 10 set bits, 11 clear bits
req_adr  input  12  CSR address
req_wdt  input  XLEN  write data / bit mask
rsp_vld  output  1  response valid
rsp_rdy  input  1  response ready
rsp_rdt  output  XLEN  CSR value before the access
rsp_err  output  2  00 OK, 01 timeout, 10 write to read-only, 11 verify mismatch
own_req  output  1  request ownership of the CSR port from the pipeline
own_gnt  input  1  pipeline stalled, CSR port muxed to this block
csr_ren  output  1  CSR read enable
csr_wen  output  1  CSR write enable
csr_adr  output  12  CSR address
csr_fn3  output  3  Zicsr funct3 (CSRRW/CSRRS/CSRRC encodings)
csr_wdt  output  XLEN  write data / mask
csr_rdt  input  XLEN  CSR read data, combinational from address

Behaviour:
- Reset: FSM in IDLE. req_rdy=1; rsp_vld=0; rsp_rdt=0; rsp_err=0; own_req=0; csr_ren=0; csr_wen=0; csr_adr=0; csr_fn3=0; csr_wdt=0; timeout counter 0.
- Reset mid-operation: abort immediately and return to IDLE. No response is issued for the aborted request.
- FSM states: IDLE, ARB, ACC, [VFY], RSP.
- IDLE:
  - req_rdy=1.
  - On req_vld&req_rdy: latch op/adr/wdt; clear timeout counter; go to ARB.
- ARB:
  - own_req=1.
  - own_gnt=1: go to ACC.
  - Otherwise: increment counter. On reaching all-ones, go to RSP with err=01 and rsp_rdt=0; no CSR strobe is ever issued.
- ACC (exactly one cycle, own_req=1):
  - csr_ren=1; csr_adr=latched adr; csr_wdt=latched wdt.
  - fn3 mapping: read → CSRRS with csr_wen=0; write → CSRRW; set → CSRRS; clear → CSRRC.
  - csr_wen=1 for op≠read, unless adr[11:10]==2'b11. In that case csr_wen=0 and err=10.
  - Capture csr_rdt into rsp_rdt at the clock edge, then go to RSP (or VFY, see Optional Feature).
- RSP:
  - own_req=0; rsp_vld=1; rsp_rdt and rsp_err held stable.
  - On rsp_rdy: go to IDLE.
- Latency:
  - Request handshake at edge N.
  - own_req high in cycle N+1.
  - If own_gnt is already high, ACC occupies cycle N+2.
  - rsp_vld high from cycle N+3.
- Exactly one request is outstanding; req_rdy=0 outside IDLE.
- own_gnt must stay high from grant until own_req falls. A drop during ACC/VFY is a protocol violation; the FSM ignores it and completes.
- Simultaneous own_gnt and timeout terminal count in ARB: grant wins.

Optional Feature:
R5P_CSR_MASTER_VERIFY_EN
- Defined:
  - Any write-class access that is not RO-blocked goes ACC→VFY.
  - VFY lasts one cycle: own_req=1, csr_ren=1, csr_wen=0, same adr.
  - Compare csr_rdt against the expected value: wdt, rdt|wdt, or rdt&~wdt.
  - Mismatch (WARL masking) → err=11. rsp_rdt still holds the pre-access value.
  - Adds 1 cycle of latency.
- Undefined: no VFY state exists and err=11 is never produced.

Decomposition:
- r5p_pkg additions: csr_mop_t enum (read/write/set/clear) and csr_merr_t enum (ok/tmo/ro/vfy).
- FSM state enum stays local to the module.
- No sub-module; the timeout counter is inline.

Test Plan:
1. Read 0x300, own_gnt tied 1, CSR returns 0x00001800 → rsp_vld at handshake+3, rsp_rdt=0x00001800, err=00, csr_wen never asserted.
2. Write 0x340 with 0xDEADBEEF, old value 0x12345678 → one-cycle csr_wen with fn3=CSRRW and csr_wdt=0xDEADBEEF; rsp_rdt=0x12345678, err=00.
3. Clear 0x300 mask 0x8 → fn3=CSRRC, csr_wdt=0x8; then set → fn3=CSRRS; each response carries the old value.
4. Write 0xC00 (cycle, read-only) → csr_ren=1, csr_wen=0, err=10, rsp_rdt=current cycle value.
5. own_gnt held 0 with TMO_W=4 → own_req high for 15 cycles, then rsp err=01, rsp_rdt=0, no csr strobes; rsp_rdy held 0 for 5 cycles → rsp_vld and data stable.
6. rst asserted during ARB → all outputs return to reset values asynchronously, no response. With VERIFY_EN: write 0xFFFFFFFF to a CSR masking to 0x0000000F → err=11.
